// File: rtl/memshare_rqst_addr_gen.sv
// memshare_rqst_addr_gen: per-channel request address generator for SCU.memShare() periods.
// Optional MEMSHARE_DRC_REBASE_EN lets a DRC0 handshake rebase every channel to drc_base_addr_i.
module memshare_rqst_addr_gen #(
  parameter int CH_NUM      = 4,
  parameter int RD_ADDR_W   = 4,
  parameter int BUFF_ADDR_W = 6,
  parameter int TRACK_DEPTH = 2,
  parameter int DRC_NUM     = 2,
  parameter int RQST_NUM    = 8
) (
  input  logic                               sys_clk,
  input  logic                               rst,
  input  logic                               scu_begin_i,
  input  logic [CH_NUM*BUFF_ADDR_W-1:0]      base_addr_i,
  input  logic [CH_NUM*RD_ADDR_W-1:0]        operand_i,
  input  logic [DRC_NUM-1:0]                 is_drc_i,
  input  logic [BUFF_ADDR_W-1:0]             drc_base_addr_i,
  input  logic                               rqst_ready_i,
  output logic                               rqst_valid_o,
  output logic [CH_NUM*BUFF_ADDR_W-1:0]      rqst_addr_o,
  output logic [CH_NUM*RD_ADDR_W-1:0]        increment_operand_o,
  output logic [BUFF_ADDR_W-1:0]             drc_base_addr_o,
  output logic [$clog2(RQST_NUM+1)-1:0]      rqst_cnt_o,
  output logic                               busy_o,
  output logic                               done_o
);
  localparam int CW = $clog2(RQST_NUM + 1);
  localparam int AW = CH_NUM * BUFF_ADDR_W;
  localparam int OW = CH_NUM * RD_ADDR_W;
  localparam int FW = TRACK_DEPTH > 1 ? $clog2(TRACK_DEPTH) : 1;
  localparam logic [RD_ADDR_W-1:0] ONE = 1;
  localparam logic [OW-1:0] OP_ONES = {CH_NUM{ONE}};

  typedef enum logic [1:0] {IDLE, FILL, ISSUE, DONE} state_t;

  state_t                        state;
  logic [FW-1:0]                 fill_cnt;
  logic [TRACK_DEPTH-1:0][OW-1:0] trk;
  logic [OW-1:0]                 live_op;
  logic [OW-1:0]                 op_hold;
  logic                          stall_q;
  logic [AW-1:0]                 addr_inc;
  logic [AW-1:0]                 addr_nxt;
  logic                          hs;
  logic                          last;
  logic                          unused_in;

  for (genvar k = 0; k < CH_NUM; k++) begin : g_ch
    assign live_op[k*RD_ADDR_W +: RD_ADDR_W] = is_drc_i[1] ? trk[TRACK_DEPTH-1][k*RD_ADDR_W +: RD_ADDR_W] : ONE;
    assign addr_inc[k*BUFF_ADDR_W +: BUFF_ADDR_W] = rqst_addr_o[k*BUFF_ADDR_W +: BUFF_ADDR_W]
                                                  + BUFF_ADDR_W'(increment_operand_o[k*RD_ADDR_W +: RD_ADDR_W]);
  end

  // a stalled request keeps showing the operand it was first presented with
  assign increment_operand_o = rst ? OP_ONES : stall_q ? op_hold : live_op;
  assign hs                  = rqst_valid_o & rqst_ready_i;
  assign last                = rqst_cnt_o == CW'(RQST_NUM - 1);
  assign unused_in           = ^{is_drc_i, drc_base_addr_i};

`ifdef MEMSHARE_DRC_REBASE_EN
  assign addr_nxt = is_drc_i[0] ? {CH_NUM{drc_base_addr_i}} : addr_inc;
`else
  assign addr_nxt        = addr_inc;
  assign drc_base_addr_o = '0;
`endif

  always_ff @(posedge sys_clk or posedge rst)
    if (rst) begin
      trk     <= '0;
      op_hold <= '0;
      stall_q <= 1'b0;
    end else begin
      trk[0] <= operand_i;
      for (int i = 1; i < TRACK_DEPTH; i++) trk[i] <= trk[i-1];
      op_hold <= increment_operand_o;
      stall_q <= rqst_valid_o & ~rqst_ready_i;
    end

  always_ff @(posedge sys_clk or posedge rst)
    if (rst) begin
      state        <= IDLE;
      fill_cnt     <= '0;
      rqst_addr_o  <= '0;
      rqst_cnt_o   <= '0;
      rqst_valid_o <= 1'b0;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
`ifdef MEMSHARE_DRC_REBASE_EN
      drc_base_addr_o <= '0;
`endif
    end else begin
      done_o <= 1'b0;
      if (scu_begin_i) begin
        state        <= FILL;
        fill_cnt     <= '0;
        rqst_addr_o  <= base_addr_i;
        rqst_cnt_o   <= '0;
        rqst_valid_o <= 1'b0;
        busy_o       <= 1'b1;
      end else
        case (state)
          FILL:
            if (fill_cnt == FW'(TRACK_DEPTH - 1)) begin
              state        <= ISSUE;
              rqst_valid_o <= 1'b1;
            end else
              fill_cnt <= fill_cnt + 1'b1;
          ISSUE:
            if (hs) begin
              rqst_addr_o <= addr_nxt;
              rqst_cnt_o  <= rqst_cnt_o + 1'b1;
`ifdef MEMSHARE_DRC_REBASE_EN
              if (is_drc_i[0]) drc_base_addr_o <= drc_base_addr_i;
`endif
              if (last) begin
                state        <= DONE;
                rqst_valid_o <= 1'b0;
                done_o       <= 1'b1;
              end
            end
          DONE: begin
            state  <= IDLE;
            busy_o <= 1'b0;
          end
          default: ;
        endcase
    end
endmodule

// File: doc/memshare_rqst_addr_gen.md
MEMSHARE_RQST_ADDR_GEN -- requirements
Module: memshare_rqst_addr_gen

Interface
REQ-001 Parameter CH_NUM, default 4: number of independent message-passing read channels.
REQ-002 Parameter RD_ADDR_W, default 4: width of each per-channel increment operand.
REQ-003 Parameter BUFF_ADDR_W, default 6: width of each per-channel buffer read address.
REQ-004 Parameter TRACK_DEPTH, default 2, legal range 1..8: operand tracking pipeline depth in cycles.
REQ-005 Parameter DRC_NUM, default 2, minimum 2: width of the DRC flag vector; bit 0 is DRC0 (rebase) and bit 1 is DRC1 (tracked-operand select).
REQ-006 Parameter RQST_NUM, default 8, minimum 1: number of requests issued per SCU.memShare() period.
REQ-007 sys_clk  in  1  single clock; all logic samples on its rising edge.
REQ-008 rst  in  1  asynchronous, active-high reset.
REQ-009 scu_begin_i  in  1  single-cycle pulse marking the start of SCU.memShare().
REQ-010 base_addr_i  in  CH_NUM*BUFF_ADDR_W  per-channel start addresses; channel k occupies bits [k*BUFF_ADDR_W +: BUFF_ADDR_W].
REQ-011 operand_i  in  CH_NUM*RD_ADDR_W  per-channel raw increment operands, using the same packing.
REQ-012 is_drc_i  in  DRC_NUM  DRC result flags.
REQ-013 drc_base_addr_i  in  BUFF_ADDR_W  rebase target address.
REQ-014 rqst_ready_i  in  1  downstream accept.
REQ-015 rqst_valid_o  out  1  request address valid.
REQ-016 rqst_addr_o  out  CH_NUM*BUFF_ADDR_W  per-channel request addresses.
REQ-017 increment_operand_o  out  CH_NUM*RD_ADDR_W  per-channel effective operand currently applied.
REQ-018 drc_base_addr_o  out  BUFF_ADDR_W  last latched rebase address.
REQ-019 rqst_cnt_o  out  $clog2(RQST_NUM+1)  number of accepted requests in the current period.
REQ-020 busy_o  out  1  high in any state except IDLE.
REQ-021 done_o  out  1  single-cycle period-complete pulse.

Function
REQ-022 The FSM SHALL have states IDLE, FILL, ISSUE and DONE.
REQ-023 In IDLE, scu_begin_i SHALL load each channel address from base_addr_i, clear rqst_cnt_o and transition to FILL.
REQ-024 Each channel SHALL delay operand_i through a TRACK_DEPTH-stage pipeline that loads every cycle.
REQ-025 FILL SHALL last exactly TRACK_DEPTH cycles and then transition to ISSUE.
REQ-026 rqst_valid_o SHALL be 1 only in ISSUE; rqst_addr_o SHALL be the registered channel addresses.
REQ-027 A handshake SHALL occur on a cycle where rqst_valid_o and rqst_ready_i are both 1.
REQ-028 While rqst_valid_o is 1 and rqst_ready_i is 0, rqst_addr_o and increment_operand_o SHALL hold stable.
REQ-029 Per channel, the effective operand SHALL be the tracked pipeline output when is_drc_i[1]=1, and 1 otherwise; increment_operand_o SHALL show this value.
REQ-030 On each handshake, each channel address SHALL become (address + zero-extended effective operand) mod 2^BUFF_ADDR_W, and rqst_cnt_o SHALL increment.
REQ-031 An effective operand of 0 SHALL leave that channel address unchanged.
REQ-032 The handshake that brings rqst_cnt_o to RQST_NUM SHALL transition the FSM to DONE.
REQ-033 DONE SHALL assert done_o for one cycle and then transition to IDLE; rqst_cnt_o SHALL hold RQST_NUM until the next scu_begin_i.
REQ-034 scu_begin_i in FILL, ISSUE or DONE SHALL abort the period, reload base_addr_i, clear the count and re-enter FILL; in DONE, done_o SHALL still pulse.
REQ-035 In any state other than ISSUE, rqst_ready_i SHALL be ignored.

Reset
REQ-036 rst=1 SHALL asynchronously force IDLE and clear to 0: all addresses, pipeline stages, rqst_cnt_o, drc_base_addr_o, rqst_valid_o, busy_o and done_o.
REQ-037 While rst=1, increment_operand_o SHALL read 1 per channel.
REQ-038 Reset asserted mid-period SHALL discard the period, with no done_o pulse.
REQ-039 After rst deasserts, operation SHALL resume on the first sys_clk edge.

Configuration
REQ-040 With macro MEMSHARE_DRC_REBASE_EN defined, a handshake with is_drc_i[0]=1 SHALL load every channel address with drc_base_addr_i, which takes priority over the increment.
REQ-041 With MEMSHARE_DRC_REBASE_EN defined, that same handshake SHALL latch drc_base_addr_i into drc_base_addr_o.
REQ-042 With MEMSHARE_DRC_REBASE_EN undefined, is_drc_i[0] SHALL be ignored and drc_base_addr_o SHALL be constant 0.

Verification
REQ-043 Defaults, base={0,8,16,24}, DRC=00, ready=1 -> after 2 FILL cycles, 8 valid cycles with ch0 addresses 0..7, then done_o pulse, rqst_cnt_o=8.
REQ-044 DRC1=1, operand ch0=3 held from 2 cycles before FILL, base 0 -> ch0 addresses 0,3,6,9,...; increment_operand_o ch0=3.
REQ-045 base ch0=62, operand 1 -> addresses 62,63,0,1 (wrap-around).
REQ-046 ready toggled 1,0,0,1 -> address held during the 0 cycles; 4 valid cycles produce 2 handshakes.
REQ-047 Macro defined, drc_base_addr_i=40, DRC0 on the 3rd handshake -> next address 40 on all channels, drc_base_addr_o=40; macro undefined -> increment continues and drc_base_addr_o=0.
REQ-048 rst pulsed during ISSUE, and separately scu_begin_i during ISSUE -> reset: IDLE, all outputs 0, no done_o; scu_begin_i: FILL re-entered, count 0, addresses reloaded.
